// File: rtl/xml_tag_matcher_if.sv
// Annotated character stream from the XML decoder plus the matcher's target
// configuration and its forwarded-data / marker outputs.
interface xml_tag_matcher_if #(
   parameter int MAXLEN = 16,
   parameter int CNTW   = 16
);
   localparam int LENW = $clog2(MAXLEN + 1);

   logic                  newMsg;
   logic [7:0]            in;
   logic                  inValid;
   logic                  isTagName;
   logic                  isData;
   logic                  isComment;
   logic [3:0]            tagDepth;
   logic [8*MAXLEN-1:0]   matchName;
   logic [LENW-1:0]       matchLen;
   logic [7:0]            out;
   logic                  outValid;
   logic                  matchStart;
   logic                  matchEnd;
   logic                  active;
   logic [3:0]            matchDepth;
   logic [CNTW-1:0]       matchCount;

   modport master (
      output newMsg, in, inValid, isTagName, isData, isComment, tagDepth,
             matchName, matchLen,
      input  out, outValid, matchStart, matchEnd, active, matchDepth, matchCount
   );

   modport slave (
      input  newMsg, in, inValid, isTagName, isData, isComment, tagDepth,
             matchName, matchLen,
      output out, outValid, matchStart, matchEnd, active, matchDepth, matchCount
   );
endinterface

// File: rtl/xml_tag_matcher.sv
// Matches completed tag names against a programmed target and forwards the
// matching element's data. Define XML_MATCH_CASEFOLD_EN for ASCII case-insensitive names.
module xml_tag_matcher #(
   parameter int MAXLEN = 16,
   parameter int CNTW   = 16
) (
   input logic              CLOCK,
   input logic              reset,
   xml_tag_matcher_if.slave bus
);
   localparam int IDXW = $clog2(MAXLEN + 2);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   state_t          r_state;
   state_t          w_state_nx;
   state_t          w_state_post;
   logic [IDXW-1:0] r_idx;
   logic            r_nameOk;
   logic            r_prevName;
   logic [3:0]      r_mdepth;
   logic [3:0]      w_mdepth_nx;
   logic [CNTW-1:0] r_count;
   logic [7:0]      r_out;
   logic            r_outValid;
   logic            r_start;
   logic            r_end;

   logic            w_cmp;
   logic            w_cmpl;
   logic            w_hit;
   logic            w_start;
   logic            w_end;
   logic            w_fwd;
   logic            w_byte_eq;
   logic [7:0]      w_tgt_byte;
   logic [IDXW-1:0] w_len;

   function automatic logic [7:0] fold(input logic [7:0] c);
`ifdef XML_MATCH_CASEFOLD_EN
      fold = (c >= 8'h41 && c <= 8'h5A) ? (c | 8'h20) : c;
`else
      fold = c;
`endif
   endfunction

   // Stops one past MAXLEN so an overlong name can never equal any matchLen.
   function automatic logic [IDXW-1:0] idx_inc(input logic [IDXW-1:0] v);
      if (v == IDXW'(MAXLEN + 1)) return v;
      return v + 1'b1;
   endfunction

   function automatic logic [CNTW-1:0] cnt_inc(input logic [CNTW-1:0] v);
      if (&v) return v;
      return v + 1'b1;
   endfunction

   always_comb begin
      w_tgt_byte = 8'h00;
      for (int k = 0; k < MAXLEN; k++) begin
         if (r_idx == IDXW'(k)) w_tgt_byte = bus.matchName[8*k +: 8];
      end
   end

   assign w_len     = IDXW'(bus.matchLen);
   assign w_byte_eq = (fold(bus.in) == fold(w_tgt_byte));
   assign w_cmp     = bus.isTagName & ~bus.isComment;
   assign w_cmpl    = ~bus.isTagName & r_prevName;
   assign w_hit     = r_nameOk & (r_idx == w_len) & (bus.matchLen != '0);

   // Depth-drop end is resolved first; the name completion then sees the post-end state.
   always_comb begin
      w_state_nx   = r_state;
      w_state_post = r_state;
      w_mdepth_nx  = r_mdepth;
      w_start      = 1'b0;
      w_end        = 1'b0;
      w_fwd        = 1'b0;
      if (bus.inValid) begin
         if (r_state == ACTIVE && bus.tagDepth < r_mdepth) begin
            w_end        = 1'b1;
            w_state_post = IDLE;
         end
         w_state_nx = w_state_post;
         if (w_cmpl) begin
            if (w_state_post == IDLE) begin
               if (w_hit) begin
                  w_start     = 1'b1;
                  w_state_nx  = ACTIVE;
                  w_mdepth_nx = bus.tagDepth;
               end
            end else if (bus.tagDepth == r_mdepth) begin
               w_end = 1'b1;
               if (w_hit) w_start = 1'b1;
               else       w_state_nx = IDLE;
            end
         end
         w_fwd = (r_state == ACTIVE) & bus.isData & ~bus.isComment & ~w_end;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (reset || bus.newMsg) r_state <= IDLE;
      else                     r_state <= w_state_nx;
   end

   always_ff @(posedge CLOCK) begin
      if (reset || bus.newMsg) begin
         r_idx      <= '0;
         r_nameOk   <= 1'b1;
         r_prevName <= 1'b0;
         r_mdepth   <= 4'd0;
         r_out      <= 8'h00;
         r_outValid <= 1'b0;
         r_start    <= 1'b0;
         r_end      <= 1'b0;
         if (reset) r_count <= '0;
      end else begin
         r_start    <= w_start;
         r_end      <= w_end;
         r_outValid <= w_fwd;
         r_out      <= w_fwd ? bus.in : 8'h00;
         r_mdepth   <= w_mdepth_nx;
         if (w_start) r_count <= cnt_inc(r_count);
         if (bus.inValid) begin
            r_prevName <= bus.isTagName;
            if (w_cmpl) begin
               r_idx    <= '0;
               r_nameOk <= 1'b1;
            end else if (w_cmp) begin
               r_nameOk <= r_nameOk & (r_idx < w_len) & w_byte_eq;
               r_idx    <= idx_inc(r_idx);
            end
         end
      end
   end

   assign bus.out        = r_out;
   assign bus.outValid   = r_outValid;
   assign bus.matchStart = r_start;
   assign bus.matchEnd   = r_end;
   assign bus.active     = (r_state == ACTIVE);
   assign bus.matchDepth = r_mdepth;
   assign bus.matchCount = r_count;
endmodule
